// File: rtl/user_pulse_decoder.sv
// user_pulse_decoder: measures period and high time of each pulse on an
// asynchronous line, groups pulses into idle-terminated bursts, and streams
// the results out over a valid/ready handshake.
//
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   enable_i, clear_i    decoder enable, synchronous soft clear
//   pulse_i              asynchronous pulse line
//   timeout_i            idle cycles that end a burst (0 = no timeout)
//   meas_*_o/_i          measurement stream (period, high, last)
//   burst_cnt_o          pulses detected in current/last burst
//   overflow_o, err_o    sticky dropped-record / stuck-high flags
//   state_o              FSM state (IDLE=0 HIGH=1 LOW=2 DONE=3)
//
// Optional: define USER_PULSE_DEC_GLITCH_FILTER_EN to require GLITCH_CYCLES
// stable cycles before the internal line level follows the synchroniser.

module user_pulse_decoder #(
    parameter int SYNC_STAGES   = 2,
    parameter int CNT_WIDTH     = 16,
    parameter int BURST_WIDTH   = 8,
    parameter int GLITCH_CYCLES = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   enable_i,
    input  logic                   clear_i,
    input  logic                   pulse_i,
    input  logic [CNT_WIDTH-1:0]   timeout_i,
    output logic                   meas_valid_o,
    input  logic                   meas_ready_i,
    output logic [CNT_WIDTH-1:0]   meas_period_o,
    output logic [CNT_WIDTH-1:0]   meas_high_o,
    output logic                   meas_last_o,
    output logic [BURST_WIDTH-1:0] burst_cnt_o,
    output logic                   overflow_o,
    output logic                   err_o,
    output logic [2:0]             state_o
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HIGH = 3'd1,
        LOW  = 3'd2,
        DONE = 3'd3
    } state_e;

    if (SYNC_STAGES < 2 || GLITCH_CYCLES < 1) begin : g_bad_param
        $error("user_pulse_decoder: SYNC_STAGES>=2 and GLITCH_CYCLES>=1");
    end

    // ---------------- input path ----------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;
    logic                   lvl;
    logic                   lvl_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_i};
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

`ifdef USER_PULSE_DEC_GLITCH_FILTER_EN
    localparam int GW = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;

    logic [GW-1:0] gcnt_q;
    logic          filt_q;

    // Count consecutive cycles the synchronised input disagrees with the
    // filtered level; flip only once it has disagreed GLITCH_CYCLES times.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            filt_q <= 1'b0;
            gcnt_q <= '0;
        end else if (sync_s != filt_q) begin
            if (gcnt_q == GW'(GLITCH_CYCLES - 1)) begin
                filt_q <= sync_s;
                gcnt_q <= '0;
            end else begin
                gcnt_q <= gcnt_q + GW'(1);
            end
        end else begin
            gcnt_q <= '0;
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = sync_s;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            lvl_q <= 1'b0;
        end else begin
            lvl_q <= lvl;
        end
    end

    logic rise;
    logic fall;

    assign rise = lvl & ~lvl_q;
    assign fall = ~lvl & lvl_q;

    // ---------------- measurement state ----------------
    state_e                 state_q;
    logic [CNT_WIDTH-1:0]   high_q;
    logic [CNT_WIDTH-1:0]   low_q;
    logic                   valid_q;
    logic [CNT_WIDTH-1:0]   period_q;
    logic [CNT_WIDTH-1:0]   mhigh_q;
    logic                   last_q;
    logic [BURST_WIDTH-1:0] burst_q;
    logic                   ovf_q;
    logic                   err_q;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(
        input logic [CNT_WIDTH-1:0] v
    );
        return (v == '1) ? v : v + CNT_WIDTH'(1);
    endfunction

    logic                 to_en;
    logic                 hi_to;
    logic                 lo_to;
    logic [CNT_WIDTH:0]   psum;
    logic [CNT_WIDTH-1:0] psat;

    assign to_en = (timeout_i != '0);
    assign hi_to = to_en && (high_q == timeout_i);
    assign lo_to = to_en && (low_q == timeout_i);
    assign psum  = {1'b0, high_q} + {1'b0, low_q};
    assign psat  = psum[CNT_WIDTH] ? '1 : psum[CNT_WIDTH-1:0];

    // Emit decision for the current cycle; timeout wins over an edge
    // arriving on the same cycle.
    logic                 emit_d;
    logic [CNT_WIDTH-1:0] e_period_d;
    logic [CNT_WIDTH-1:0] e_high_d;
    logic                 e_last_d;

    always_comb begin
        emit_d     = 1'b0;
        e_period_d = '0;
        e_high_d   = high_q;
        e_last_d   = 1'b0;
        if (enable_i) begin
            unique case (state_q)
                HIGH: begin
                    if (hi_to) begin
                        emit_d   = 1'b1;
                        e_high_d = timeout_i;
                        e_last_d = 1'b1;
                    end
                end
                LOW: begin
                    if (lo_to) begin
                        emit_d   = 1'b1;
                        e_last_d = 1'b1;
                    end else if (rise) begin
                        emit_d     = 1'b1;
                        e_period_d = psat;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            high_q   <= '0;
            low_q    <= '0;
            valid_q  <= 1'b0;
            period_q <= '0;
            mhigh_q  <= '0;
            last_q   <= 1'b0;
            burst_q  <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else if (clear_i) begin
            state_q <= IDLE;
            high_q  <= '0;
            low_q   <= '0;
            valid_q <= 1'b0;
            burst_q <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // Output register: a held, unaccepted record is never replaced.
            if (emit_d) begin
                if (!valid_q || meas_ready_i) begin
                    valid_q  <= 1'b1;
                    period_q <= e_period_d;
                    mhigh_q  <= e_high_d;
                    last_q   <= e_last_d;
                end else begin
                    ovf_q <= 1'b1;
                end
                if (burst_q != '1) begin
                    burst_q <= burst_q + BURST_WIDTH'(1);
                end
            end else if (valid_q && meas_ready_i) begin
                valid_q <= 1'b0;
            end

            if (!enable_i) begin
                state_q <= IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (rise) begin
                            state_q <= HIGH;
                            high_q  <= CNT_WIDTH'(1);
                            burst_q <= '0;
                        end
                    end
                    HIGH: begin
                        if (hi_to) begin
                            err_q   <= 1'b1;
                            state_q <= DONE;
                        end else if (fall) begin
                            state_q <= LOW;
                            low_q   <= CNT_WIDTH'(1);
                        end else begin
                            high_q <= sat_inc(high_q);
                        end
                    end
                    LOW: begin
                        if (lo_to) begin
                            state_q <= DONE;
                        end else if (rise) begin
                            state_q <= HIGH;
                            high_q  <= CNT_WIDTH'(1);
                        end else begin
                            low_q <= sat_inc(low_q);
                        end
                    end
                    DONE: state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign meas_valid_o  = valid_q;
    assign meas_period_o = period_q;
    assign meas_high_o   = mhigh_q;
    assign meas_last_o   = last_q;
    assign burst_cnt_o   = burst_q;
    assign overflow_o    = ovf_q;
    assign err_o         = err_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_user_pulse_decoder.sv
// Directed self-checking bench for user_pulse_decoder.
// Drives inputs on the falling edge, collects accepted records at rising edges.

module tb_user_pulse_decoder;

    localparam int CW = 16;
    localparam int BW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          clear;
    logic          pulse;
    logic [CW-1:0] timeout;
    logic          valid;
    logic          ready;
    logic [CW-1:0] period;
    logic [CW-1:0] high;
    logic          last;
    logic [BW-1:0] burst;
    logic          ovf;
    logic          err;
    logic [2:0]    state;

    user_pulse_decoder #(
        .SYNC_STAGES  (2),
        .CNT_WIDTH    (CW),
        .BURST_WIDTH  (BW),
        .GLITCH_CYCLES(3)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .enable_i     (enable),
        .clear_i      (clear),
        .pulse_i      (pulse),
        .timeout_i    (timeout),
        .meas_valid_o (valid),
        .meas_ready_i (ready),
        .meas_period_o(period),
        .meas_high_o  (high),
        .meas_last_o  (last),
        .burst_cnt_o  (burst),
        .overflow_o   (ovf),
        .err_o        (err),
        .state_o      (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] p;
        logic [CW-1:0] h;
        logic          l;
    } rec_t;

    rec_t q[$];
    int   tests = 0;
    int   fails = 0;

    always @(posedge clk) begin
        if (rst_n && !clear && valid && ready) begin
            q.push_back('{p: period, h: high, l: last});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rec(input string tag, input int idx,
                           input int p, input int h, input int l);
        rec_t r;
        r = '0;
        if (idx < q.size()) r = q[idx];
        chk({tag, ".p"}, 32'(r.p), p);
        chk({tag, ".h"}, 32'(r.h), h);
        chk({tag, ".l"}, 32'(r.l), l);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pls(input int p, input int h);
        pulse = 1'b1;
        cyc(h);
        pulse = 1'b0;
        cyc(p - h);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
    endtask

    // 4 high, 3 low, 2-cycle glitch, 1 low: clean period 10 / high 4
    task automatic glitch_pls();
        logic [9:0] pat;
        pat = 10'b1111000110;
        for (int i = 9; i >= 0; i--) begin
            pulse = pat[i];
            cyc(1);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        enable  = 1'b1;
        clear   = 1'b0;
        pulse   = 1'b0;
        timeout = 16'd50;
        ready   = 1'b1;
        cyc(3);
        chk("rst.valid", 32'(valid), 0);
        chk("rst.burst", 32'(burst), 0);
        chk("rst.ovf", 32'(ovf), 0);
        chk("rst.err", 32'(err), 0);
        chk("rst.state", 32'(state), 0);
        rst_n = 1'b1;
        cyc(2);

        // basic burst of three pulses
        q.delete();
        repeat (3) pls(10, 4);
        cyc(70);
        chk("b1.n", 32'(q.size()), 3);
        chk_rec("b1.r0", 0, 10, 4, 0);
        chk_rec("b1.r1", 1, 10, 4, 0);
        chk_rec("b1.r2", 2, 0, 4, 1);
        chk("b1.burst", 32'(burst), 3);
        chk("b1.err", 32'(err), 0);
        chk("b1.state", 32'(state), 0);

        // frequency change inside one burst
        do_clear();
        q.delete();
        timeout = 16'd100;
        repeat (2) pls(20, 8);
        repeat (2) pls(12, 3);
        cyc(120);
        chk("b2.n", 32'(q.size()), 4);
        chk_rec("b2.r0", 0, 20, 8, 0);
        chk_rec("b2.r1", 1, 20, 8, 0);
        chk_rec("b2.r2", 2, 12, 3, 0);
        chk_rec("b2.r3", 3, 0, 3, 1);
        chk("b2.burst", 32'(burst), 4);

        // back-pressure: second record dropped
        do_clear();
        q.delete();
        ready   = 1'b0;
        timeout = 16'd50;
        repeat (2) pls(10, 4);
        chk("bp.valid0", 32'(valid), 1);
        chk("bp.p0", 32'(period), 10);
        chk("bp.ovf0", 32'(ovf), 0);
        cyc(70);
        chk("bp.valid1", 32'(valid), 1);
        chk("bp.p1", 32'(period), 10);
        chk("bp.h1", 32'(high), 4);
        chk("bp.l1", 32'(last), 0);
        chk("bp.ovf1", 32'(ovf), 1);
        chk("bp.burst", 32'(burst), 2);
        chk("bp.n", 32'(q.size()), 0);
        do_clear();
        chk("clr.valid", 32'(valid), 0);
        chk("clr.ovf", 32'(ovf), 0);
        chk("clr.burst", 32'(burst), 0);
        ready = 1'b1;
        cyc(2);

        // stuck-high line
        q.delete();
        timeout = 16'd16;
        pulse   = 1'b1;
        for (int i = 0; i < 40 && !valid; i++) cyc(1);
        chk("sh.valid", 32'(valid), 1);
        chk("sh.p", 32'(period), 0);
        chk("sh.h", 32'(high), 16);
        chk("sh.l", 32'(last), 1);
        chk("sh.err", 32'(err), 1);
        chk("sh.done", 32'(state), 3);
        cyc(1);
        chk("sh.idle", 32'(state), 0);
        cyc(10);
        pulse = 1'b0;
        cyc(5);
        chk("sh.n", 32'(q.size()), 1);

        // enable dropped mid-HIGH: aborted pulse produces nothing
        q.delete();
        timeout = 16'd50;
        pulse   = 1'b1;
        cyc(4);
        chk("en.high", 32'(state), 1);
        chk("en.burst0", 32'(burst), 0);
        enable = 1'b0;
        cyc(2);
        chk("en.idle", 32'(state), 0);
        cyc(2);
        pulse = 1'b0;
        cyc(6);
        enable = 1'b1;
        cyc(2);
        chk("en.n0", 32'(q.size()), 0);
        chk("en.err", 32'(err), 1);
        repeat (2) pls(10, 4);
        cyc(70);
        chk("en.n", 32'(q.size()), 2);
        chk_rec("en.r0", 0, 10, 4, 0);
        chk_rec("en.r1", 1, 0, 4, 1);
        chk("en.burst", 32'(burst), 2);

        // reset in the middle of a burst
        q.delete();
        ready = 1'b0;
        repeat (2) pls(10, 4);
        pulse = 1'b1;
        cyc(3);
        chk("mr.pre", 32'(valid), 1);
        rst_n = 1'b0;
        cyc(1);
        chk("mr.valid", 32'(valid), 0);
        chk("mr.p", 32'(period), 0);
        chk("mr.h", 32'(high), 0);
        chk("mr.burst", 32'(burst), 0);
        chk("mr.err", 32'(err), 0);
        chk("mr.state", 32'(state), 0);
        rst_n = 1'b1;
        pulse = 1'b0;
        ready = 1'b1;
        cyc(5);

        // short glitches inside the low time
        do_clear();
        q.delete();
        repeat (3) glitch_pls();
        cyc(70);
`ifdef USER_PULSE_DEC_GLITCH_FILTER_EN
        chk("gl.n", 32'(q.size()), 3);
        chk_rec("gl.r0", 0, 10, 4, 0);
        chk_rec("gl.r1", 1, 10, 4, 0);
        chk_rec("gl.r2", 2, 0, 4, 1);
`else
        chk("gl.n", 32'(q.size()), 6);
        chk_rec("gl.r0", 0, 7, 4, 0);
        chk_rec("gl.r1", 1, 3, 2, 0);
        chk_rec("gl.r5", 5, 0, 2, 1);
        chk("gl.burst", 32'(burst), 6);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
